// File: rtl/udp_pkt_reader.sv
// Streams one frozen frame of the ping-pong UDP payload buffer as a single valid/ready packet.
// Reads are credit-limited so the skid FIFO absorbs the RAM latency under backpressure.
module udp_pkt_reader #(
    parameter int unsigned PKT_WORDS  = 527,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_msync_n,
    output logic [9:0]  o_rd_addr,
    input  logic [31:0] i_rd_data,
    output logic [31:0] o_st_data,
    output logic        o_st_valid,
    output logic        o_st_sop,
    output logic        o_st_eop,
    output logic        o_st_err,
    input  logic        i_st_ready,
    output logic        o_busy,
    output logic [15:0] o_drop_cnt
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IF_W  = $clog2(RD_LAT + 1);
    localparam int unsigned OCC_W = ((CNT_W > IF_W) ? CNT_W : IF_W) + 1;

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StAbort} state_e;

    state_e             state_q, state_d;
    logic               msync_n_q;
    logic               msync;
    logic [9:0]         addr_q, addr_d;
    logic               start;
    logic               issue;
    logic [RD_LAT-1:0]  vld_q, sop_tag_q, eop_tag_q;
    logic [IF_W-1:0]    inflight;
    logic [OCC_W-1:0]   occupancy;
    logic [31:0]        fifo_data_q [FIFO_DEPTH];
    logic               fifo_sop_q  [FIFO_DEPTH];
    logic               fifo_eop_q  [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   fifo_cnt_q;
    logic               fifo_empty;
    logic               push, pop;
    logic               eop_pushed_q;
    logic               term_valid, term_accept;
    logic [15:0]        drop_cnt_q;

    assign msync = msync_n_q & ~i_msync_n;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + IF_W'(vld_q[i]);
        end
    end

    assign occupancy  = OCC_W'(fifo_cnt_q) + OCC_W'(inflight);
    assign fifo_empty = (fifo_cnt_q == '0);
    assign issue      = (state_q == StRead) && (addr_q < 10'(PKT_WORDS)) &&
                        (occupancy < OCC_W'(FIFO_DEPTH));
    assign push       = vld_q[RD_LAT-1];
    assign pop        = ~fifo_empty & i_st_ready;

    // The terminator is only offered once every word of the cut packet has left the FIFO.
    assign term_valid  = (state_q == StAbort) && (inflight == '0) && fifo_empty && ~eop_pushed_q;
    assign term_accept = term_valid & i_st_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        start   = 1'b0;
        if (issue) begin
            addr_d = addr_q + 10'd1;
        end
        case (state_q)
            StIdle: begin
                if (msync) begin
                    state_d = StRead;
                    start   = 1'b1;
                end
            end
            StRead: begin
                if (msync) begin
                    state_d = StAbort;
                end else if (issue && (addr_q == 10'(PKT_WORDS - 1))) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (msync) begin
                    state_d = StAbort;
                end else if (pop && fifo_eop_q[rd_ptr_q]) begin
                    state_d = StIdle;
                end
            end
            StAbort: begin
                // A packet whose eop already landed ends cleanly; restart without a terminator.
                if ((inflight == '0) && fifo_empty && (eop_pushed_q || term_accept)) begin
                    state_d = StRead;
                    start   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (start) begin
            addr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            msync_n_q    <= 1'b1;
            addr_q       <= '0;
            eop_pushed_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q   <= state_d;
            msync_n_q <= i_msync_n;
            addr_q    <= addr_d;
            if (start) begin
                eop_pushed_q <= 1'b0;
            end else if (push && eop_tag_q[RD_LAT-1]) begin
                eop_pushed_q <= 1'b1;
            end
            if (term_accept && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q     <= '0;
            sop_tag_q <= '0;
            eop_tag_q <= '0;
        end else begin
            vld_q[0]     <= issue;
            sop_tag_q[0] <= issue && (addr_q == '0);
            eop_tag_q[0] <= issue && (addr_q == 10'(PKT_WORDS - 1));
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]     <= vld_q[i-1];
                sop_tag_q[i] <= sop_tag_q[i-1];
                eop_tag_q[i] <= eop_tag_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_sop_q[i]  <= 1'b0;
                fifo_eop_q[i]  <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= i_rd_data;
                fifo_sop_q[wr_ptr_q]  <= sop_tag_q[RD_LAT-1];
                fifo_eop_q[wr_ptr_q]  <= eop_tag_q[RD_LAT-1];
                wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    assign o_rd_addr  = addr_q;
    assign o_st_valid = ~fifo_empty | term_valid;
    assign o_st_data  = term_valid ? 32'hFFFF_FFFF : fifo_data_q[rd_ptr_q];
    assign o_st_sop   = ~fifo_empty & fifo_sop_q[rd_ptr_q];
    assign o_st_eop   = (~fifo_empty & fifo_eop_q[rd_ptr_q]) | term_valid;
    assign o_st_err   = term_valid;
    assign o_busy     = (state_q != StIdle);
    assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_udp_pkt_reader.sv
// Bench for udp_pkt_reader: RAM returns data = address; a packet-grammar model checks every
// accepted word, stall stability and the drop counter, plus hand-computed timing points.
module tb_udp_pkt_reader;

    localparam int PKT = 527;

    logic        clk = 1'b0;
    logic        rst;
    logic        msync_n;
    logic [9:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] st_data;
    logic        st_valid, st_sop, st_eop, st_err;
    logic        ready;
    logic        busy;
    logic [15:0] drop_cnt;
    logic [9:0]  ram_a1;

    always #5 clk = ~clk;

    // Two-clock read latency: address registered, then data registered.
    always @(posedge clk) begin
        ram_a1  <= rd_addr;
        rd_data <= {22'd0, ram_a1};
    end

    udp_pkt_reader #(.PKT_WORDS(PKT), .RD_LAT(2), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_msync_n  (msync_n),
        .o_rd_addr  (rd_addr),
        .i_rd_data  (rd_data),
        .o_st_data  (st_data),
        .o_st_valid (st_valid),
        .o_st_sop   (st_sop),
        .o_st_eop   (st_eop),
        .o_st_err   (st_err),
        .i_st_ready (ready),
        .o_busy     (busy),
        .o_drop_cnt (drop_cnt)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ready_mode = 1;
    int          m_idx = 0;
    bit          m_in_pkt = 0;
    int          m_drop = 0;
    int          n_pkts = 0;
    int          n_term = 0;
    int          term_len = 0;
    int          sop_cyc = 0;
    int          eop_cyc = 0;
    int          stall_cnt = 0;
    int          target;
    bit          prev_stall = 0;
    logic [31:0] p_data;
    logic        p_sop, p_eop, p_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    // One cycle: drive ready for the coming edge, then check the stream against the model.
    task automatic tick();
        @(negedge clk);
        cyc++;
        case (ready_mode)
            0:       ready = 1'b0;
            1:       ready = 1'b1;
            default: ready = 1'($urandom_range(0, 1));
        endcase
        if (rst) begin
            m_idx = 0; m_in_pkt = 0; m_drop = 0; prev_stall = 0;
        end else begin
            chk("drop_cnt", {16'd0, drop_cnt}, m_drop);
            if (prev_stall) begin
                chkb("stall_valid", st_valid, 1'b1);
                chk("stall_data", st_data, p_data);
                chkb("stall_sop", st_sop, p_sop);
                chkb("stall_eop", st_eop, p_eop);
                chkb("stall_err", st_err, p_err);
            end
            if (st_valid) begin
                if (st_err) chkb("err_needs_eop", st_eop, 1'b1);
                if (ready) begin
                    if (st_err) begin
                        chkb("term_in_pkt", m_in_pkt, 1'b1);
                        chk("term_data", st_data, 32'hFFFF_FFFF);
                        chkb("term_sop", st_sop, 1'b0);
                        term_len = m_idx;
                        n_term++;
                        if (m_drop < 65535) m_drop++;
                        m_idx = 0;
                        m_in_pkt = 0;
                    end else begin
                        chkb("word_sop", st_sop, m_idx == 0);
                        chk("word_data", st_data, m_idx);
                        chkb("word_eop", st_eop, m_idx == PKT - 1);
                        if (m_idx == 0) sop_cyc = cyc;
                        if (m_idx == PKT - 1) begin
                            eop_cyc = cyc;
                            n_pkts++;
                            m_idx = 0;
                            m_in_pkt = 0;
                        end else begin
                            m_idx++;
                            m_in_pkt = 1;
                        end
                    end
                end else begin
                    stall_cnt++;
                end
            end
            prev_stall = st_valid && !ready;
            p_data = st_data; p_sop = st_sop; p_eop = st_eop; p_err = st_err;
        end
    endtask

    task automatic start_pkt();
        tick();
        tick();
        msync_n = 1'b0;
        tick();
        msync_n = 1'b1;
    endtask

    task automatic wait_pkts(input int tgt);
        for (int n = 0; n < 4000 && n_pkts < tgt; n++) tick();
        chkb("pkt_complete", n_pkts >= tgt, 1'b1);
    endtask

    task automatic wait_word(input logic [31:0] val);
        bit hit = 0;
        for (int n = 0; n < 3000 && !hit; n++) begin
            tick();
            hit = st_valid && ready && !st_err && (st_data == val);
        end
        chkb("wait_word", hit, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        msync_n = 1'b1;
        ready = 1'b1;
        tick();
        chkb("rst_valid", st_valid, 1'b0);
        chkb("rst_busy", busy, 1'b0);
        chk("rst_addr", {22'd0, rd_addr}, 32'd0);
        chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
        rst = 1'b0;

        // Full-rate packet with pinned latency points.
        tick();
        tick();
        msync_n = 1'b0;
        tick();
        msync_n = 1'b1;
        chkb("lat_busy", busy, 1'b1);
        chk("lat_addr0", {22'd0, rd_addr}, 32'd0);
        tick();
        chk("lat_addr1", {22'd0, rd_addr}, 32'd1);
        chkb("lat_valid2", st_valid, 1'b0);
        tick();
        chkb("lat_valid3", st_valid, 1'b0);
        tick();
        chkb("lat_valid4", st_valid, 1'b1);
        chkb("lat_sop", st_sop, 1'b1);
        chk("lat_data", st_data, 32'd0);
        wait_pkts(1);
        chk("no_gap", eop_cyc - sop_cyc, PKT - 1);
        tick();
        chkb("busy_after_eop", busy, 1'b0);
        chkb("valid_after_eop", st_valid, 1'b0);

        // Random backpressure.
        ready_mode = 2;
        start_pkt();
        wait_pkts(2);
        chkb("stalls_seen", stall_cnt > 0, 1'b1);

        // Long stall right after start: credits stop the address at the FIFO depth.
        ready_mode = 0;
        start_pkt();
        for (int i = 0; i < 100; i++) tick();
        chk("stall_addr", {22'd0, rd_addr}, 32'd4);
        chkb("stall_head_sop", st_sop, 1'b1);
        chk("stall_head_data", st_data, 32'd0);
        ready_mode = 1;
        wait_pkts(3);

        // Abort at word 200: words 0..203 already committed, then the terminator.
        tick();
        start_pkt();
        wait_word(200);
        msync_n = 1'b0;
        tick();
        msync_n = 1'b1;
        for (int n = 0; n < 100 && n_term < 1; n++) tick();
        chk("term_count", n_term, 1);
        chk("term_len", term_len, 204);
        tick();
        chk("drop_one", {16'd0, drop_cnt}, 32'd1);
        wait_pkts(4);

        // Sync coincident with acceptance of the last word: no terminator.
        start_pkt();
        wait_word(PKT - 1);
        msync_n = 1'b0;
        tick();
        msync_n = 1'b1;
        target = n_pkts + 1;
        wait_pkts(target);
        chk("no_extra_term", n_term, 1);
        chk("drop_still_one", {16'd0, drop_cnt}, 32'd1);

        // Reset mid-packet.
        tick();
        start_pkt();
        wait_word(100);
        rst = 1'b1;
        #1;
        chkb("mid_rst_valid", st_valid, 1'b0);
        chkb("mid_rst_eop", st_eop, 1'b0);
        chkb("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_addr", {22'd0, rd_addr}, 32'd0);
        chk("mid_rst_drop", {16'd0, drop_cnt}, 32'd0);
        tick();
        rst = 1'b0;
        target = n_pkts + 1;
        start_pkt();
        wait_pkts(target);
        chk("post_rst_drop", {16'd0, drop_cnt}, 32'd0);
        tick();
        chkb("post_rst_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
